// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised UART receiver with a one-word holding register.
//
// Purpose: receives asynchronous serial frames (start, DATA_BITS data bits LSB
// first, optional parity bit, one stop bit) sampled at mid-bit. It filters
// start-bit glitches and flags parity and framing errors. Each received word
// is offered on a valid/ready handshake. A sticky overrun flag records any
// word that was dropped because the holding register was still full.
//
// Parameters:
//   CLKS_PER_BIT  sysclk cycles per serial bit (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//
// Ports:
//   sysclk       in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   UART_RX      in   asynchronous serial line, idle high
//   enable       in   receiver enable; low aborts any frame in progress
//   rx_data      out  received word
//   rx_valid     out  holding register full
//   rx_ready     in   consumer accepts the word when rx_valid && rx_ready
//   parity_err   out  parity mismatch for the word in rx_data
//   frame_err    out  stop bit was sampled low for the word in rx_data
//   overrun      out  sticky: a completed word was dropped
//   clr_overrun  in   clears overrun (a new overrun in the same cycle wins)
//   busy         out  receiver FSM is not idle
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 UART_RX,
  input  logic                 enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_t;

  // Two-flop synchroniser; both flops sit at the idle line level in reset.
  logic sync1_q, rxs_q;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   load, load_ferr, hs;

  logic [DATA_BITS-1:0]   data_q;
  logic                   valid_q, perr_out_q, ferr_q, ovr_q, busy_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= UART_RX;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    load      = 1'b0;
    load_ferr = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // The cycle that first sees the line low is count 0, so the START
        // state begins at count 1 and the mid-start sample lands at t0+N/2-1.
        if (enable && !rxs_q) begin
          state_d = S_START;
          cnt_d   = CW'(1);
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line already back high at mid-start: treat as a glitch.
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          // XOR over data and parity bit is 1 for a good odd frame, 0 for even.
          perr_d  = (PARITY == 1) ? ~(^shift_q ^ rxs_q) : (^shift_q ^ rxs_q);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          load      = 1'b1;
          load_ferr = ~rxs_q;
          // A low stop bit may be a break; wait for the line to idle before
          // accepting another start edge.
          state_d   = rxs_q ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      load    = 1'b0;
    end
  end

  assign hs = valid_q && rx_ready;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      busy_q  <= (state_d != S_IDLE);

      // A load is accepted when the register is empty or being emptied now.
      if (load && (!valid_q || hs)) begin
        data_q     <= shift_q;
        perr_out_q <= (PARITY != 0) ? perr_q : 1'b0;
        ferr_q     <= load_ferr;
        valid_q    <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end

      if (load && valid_q && !hs) begin
        ovr_q <= 1'b1;
      end else if (clr_overrun) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;

endmodule
